d16_wb_uart: RTL
================

// Module: d16_wb_uart
// PURPOSE
//  Wishbone responder for the d16 core bus: memory-mapped 8N1 UART, 4 x 16-bit regs.
//  Answers the CPU's single-cycle cyc/we accesses: no ack, no stall, zero wait states.
//  Read data is combinational; writes and read side effects take effect on the access edge.
//  o_int drives the CPU i_int.
// PARAMETERS
//  BASE_ADDR    16'hFF00  word address of reg 0; must be 4-aligned
//  DEFAULT_DIV  16'd103   reset value of BAUD; bit period = DIV+1 clocks
// PORTS
//  i_clk        in   1   single clock, all logic on posedge
//  i_reset      in   1   synchronous reset, active-high
//  i_wb_addr    in   16  word address from CPU
//  i_wb_cyc     in   1   access strobe, one cycle per access
//  i_wb_we      in   1   1 = write
//  i_wb_dat     in   16  write data
//  o_wb_dat     out  16  read data; 0 when not selected (OR-able onto bus)
//  o_sel        out  1   combinational: i_wb_cyc && addr[15:2]==BASE_ADDR[15:2]
//  o_uart_tx    out  1   serial out, idle high
//  i_uart_rx    in   1   serial in, asynchronous
//  o_int        out  1   level interrupt, registered
// BEHAVIOUR
//  Reset: o_uart_tx=1, o_int=0, BAUD=DEFAULT_DIV, CTRL=0, status flags 0.
//  Reset: RX storage empty, TX/RX FSMs IDLE.
//  Reset mid-frame aborts the frame: TX line high the next cycle.
//  Registers, offset = addr[1:0]:
//   0 DATA   R: {8'h0, rx byte}, pops RX. W: bits[7:0] start TX.
//   1 STATUS [0] rx_valid, [1] tx_busy, [2] rx_overrun, [3] rx_frame_err, [4] tx_drop.
//            W1C on bits 2..4; bits 0..1 are read-only.
//   2 BAUD   R/W 16-bit divisor; written value takes effect at the next bit boundary.
//   3 CTRL   [0] rx_int_en, [1] tx_int_en; R/W.
//  Access rule: any o_sel && !we edge counts as a read, including instruction fetch.
//   Reading DATA with rx empty returns the last byte; no pop, no error.
//  TX FSM IDLE->START->DATA(8, LSB first)->STOP->IDLE; each state lasts DIV+1 clocks.
//   Write to DATA in IDLE: o_uart_tx low and tx_busy=1 from the next cycle.
//   Full frame is 10*(DIV+1) clocks; tx_busy clears in the cycle after the STOP period.
//   Write to DATA while busy is ignored and sets tx_drop.
//  RX: 2-FF synchronizer, then FSM IDLE->START->DATA->STOP.
//   Falling edge in IDLE starts the counter; sample point is (DIV+1)/2 clocks in.
//   START sample high = glitch, return to IDLE with no flags.
//   Data bits sampled every DIV+1 clocks at mid-bit.
//   STOP sample low: byte discarded, rx_frame_err set.
//   Valid byte with storage full: byte dropped, rx_overrun set.
//   Push and pop in the same cycle on full storage: both happen, no overrun.
//  o_int <= (rx_int_en & rx_valid) | (tx_int_en & !tx_busy); one-cycle latency.
//  Counters 16-bit; DIV=0 is legal (1 clock/bit).
// CONFIGURATION
//  D16_UART_RXFIFO_EN defined: RX storage is a 4-entry FIFO.
//   2-bit wrapping pointers plus 3-bit count; rx_valid = count!=0.
//  Undefined: single holding register; rx_valid = holding full.
//  Register map and flags are identical in both builds.
// STRUCTURE
//  d16_pkg: register offsets, STATUS/CTRL bit indices, TX/RX state encodings.
//  Sub-module d16_uart_rx: synchronizer, RX FSM, bit counter.
//   Outputs a byte strobe and a frame_err strobe to the top.
//  Top holds: bus decode, regs, TX FSM, RX storage, interrupt.
// TESTING (DIV=3, BASE_ADDR=16'hFF00)
//  1. Reset, then read FF01 -> 16'h0000; read FF02 -> 16'h0003; o_uart_tx=1, o_int=0.
//  2. Write FF00=16'h00A5 -> tx low for 4 clks, then bits 1,0,1,0,0,1,0,1 at 4 clks each.
//     Stop high; tx_busy 1 for exactly 40 clks.
//  3. Write FF00 twice back-to-back -> second byte never sent; STATUS[4]=1.
//     Write FF01=16'h0010 clears it.
//  4. Drive 0x3C on i_uart_rx -> STATUS[0]=1; read FF00 -> 16'h003C, STATUS[0]=0.
//     With CTRL=1, o_int high until the pop.
//  5. Drive frame with stop=0 -> STATUS[3]=1, rx_valid stays 0.
//     2-clk low glitch -> no flags.
//  6. Send 5 bytes without reads -> FIFO build: 4 kept, STATUS[2]=1; else 1 kept, overrun.
//     Assert i_reset mid-TX -> tx high next clk, all regs at reset values.

Source files
------------

// File: rtl/d16_pkg.sv
// Shared register offsets, STATUS/CTRL bit positions and FSM encodings for the d16 UART.
package d16_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_BAUD   = 2'd2,
    REG_CTRL   = 2'd3
  } reg_off_t;

  localparam int ST_RX_VALID     = 0;
  localparam int ST_TX_BUSY      = 1;
  localparam int ST_RX_OVERRUN   = 2;
  localparam int ST_RX_FRAME_ERR = 3;
  localparam int ST_TX_DROP      = 4;

  localparam int CTRL_RX_INT_EN = 0;
  localparam int CTRL_TX_INT_EN = 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/d16_uart_rx.sv
// 8N1 receiver: 2-FF synchronizer, start/data/stop FSM, mid-bit sampling.
// Emits one-cycle byte and frame-error strobes; the byte stays valid on o_byte.
module d16_uart_rx
  import d16_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rx,
  input  logic [15:0] i_div,
  output logic        o_byte_stb,
  output logic [7:0]  o_byte,
  output logic        o_frame_err
);

  logic [1:0]  sync;
  logic        rx_prev;
  logic        rx_s;
  logic        fall;
  logic [15:0] half;

  rx_state_t   state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [2:0]  bit_idx, bit_d;
  logic [7:0]  shift, shift_d;

  assign rx_s = sync[1];
  assign fall = rx_prev & ~rx_s;
  // Offset of the start-bit sample from the detected edge; 0 only when DIV=0.
  assign half = 16'(({1'b0, i_div} + 17'd1) >> 1);

  // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would chain the synchronizer into one stage.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      sync    <= {sync[0], i_rx};
      rx_prev <= rx_s;
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      shift   <= shift_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    bit_d       = bit_idx;
    shift_d     = shift;
    o_byte_stb  = 1'b0;
    o_frame_err = 1'b0;
    case (state)
      RX_IDLE: begin
        if (fall) begin
          if (half == 16'd0) begin
            state_d = RX_DATA;
            cnt_d   = i_div;
            bit_d   = '0;
          end else begin
            state_d = RX_START;
            cnt_d   = half - 16'd1;
          end
        end
      end
      RX_START: begin
        if (cnt != 16'd0) cnt_d = cnt - 16'd1;
        else if (rx_s)    state_d = RX_IDLE;
        else begin
          state_d = RX_DATA;
          cnt_d   = i_div;
          bit_d   = '0;
        end
      end
      RX_DATA: begin
        if (cnt != 16'd0) cnt_d = cnt - 16'd1;
        else begin
          shift_d = {rx_s, shift[7:1]};
          cnt_d   = i_div;
          bit_d   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt != 16'd0) cnt_d = cnt - 16'd1;
        else begin
          state_d     = RX_IDLE;
          o_byte_stb  = rx_s;
          o_frame_err = ~rx_s;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign o_byte = shift;

endmodule

// File: rtl/d16_wb_uart.sv
// Zero-wait-state Wishbone UART for the d16 core: DATA/STATUS/BAUD/CTRL, TX FSM, RX storage, IRQ.
// Define D16_UART_RXFIFO_EN for a 4-entry RX FIFO; otherwise a single holding register is used.
module d16_wb_uart
  import d16_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_wb_addr,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [15:0] i_wb_dat,
  output logic [15:0] o_wb_dat,
  output logic        o_sel,
  output logic        o_uart_tx,
  input  logic        i_uart_rx,
  output logic        o_int
);

  reg_off_t    off;
  logic        wr, wr_data, rd_data;
  logic [15:0] baud;
  logic [1:0]  ctrl;
  logic        rx_overrun, rx_frame_err, tx_drop;
  logic        tx_busy;

  logic        rx_byte_stb, rx_frame_stb;
  logic [7:0]  rx_byte;
  logic        rx_valid, push, pop, overrun_set;
  logic [7:0]  rx_byte_rd;

  assign off     = reg_off_t'(i_wb_addr[1:0]);
  assign o_sel   = i_wb_cyc && (i_wb_addr[15:2] == BASE_ADDR[15:2]);
  assign wr      = o_sel && i_wb_we;
  assign wr_data = wr && (off == REG_DATA);
  assign rd_data = o_sel && !i_wb_we && (off == REG_DATA);

  // ---------------- TX ----------------
  tx_state_t   tx_state, tx_state_d;
  logic [15:0] tx_cnt, tx_cnt_d;
  logic [2:0]  tx_bit, tx_bit_d;
  logic [7:0]  tx_shift, tx_shift_d;
  logic        tx_line, tx_line_d;

  assign tx_busy   = (tx_state != TX_IDLE);
  assign o_uart_tx = tx_line;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_shift <= tx_shift_d;
      tx_line  <= tx_line_d;
    end
  end

  // BAUD is reloaded at every bit boundary, so a new divisor applies from the next bit.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    tx_line_d  = tx_line;
    case (tx_state)
      TX_IDLE: begin
        if (wr_data) begin
          tx_state_d = TX_START;
          tx_cnt_d   = baud;
          tx_shift_d = i_wb_dat[7:0];
          tx_line_d  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt != 16'd0) tx_cnt_d = tx_cnt - 16'd1;
        else begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = baud;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt != 16'd0) tx_cnt_d = tx_cnt - 16'd1;
        else begin
          tx_cnt_d = baud;
          if (tx_bit == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_shift_d = {1'b0, tx_shift[7:1]};
            tx_bit_d   = tx_bit + 3'd1;
            tx_line_d  = tx_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt != 16'd0) tx_cnt_d = tx_cnt - 16'd1;
        else                 tx_state_d = TX_IDLE;
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_line_d  = 1'b1;
      end
    endcase
  end

  // ---------------- RX ----------------
  d16_uart_rx u_rx (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_rx        (i_uart_rx),
    .i_div       (baud),
    .o_byte_stb  (rx_byte_stb),
    .o_byte      (rx_byte),
    .o_frame_err (rx_frame_stb)
  );

`ifdef D16_UART_RXFIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic [7:0] last_byte;

  assign rx_valid    = (count != 3'd0);
  assign pop         = rd_data && rx_valid;
  assign push        = rx_byte_stb && ((count != 3'd4) || pop);
  assign overrun_set = rx_byte_stb && (count == 3'd4) && !pop;
  assign rx_byte_rd  = rx_valid ? fifo_mem[rd_ptr] : last_byte;

  // NOTE: storage array has no reset; count gates every read, so its contents never matter while empty.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_byte <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 2'd1;
        last_byte <= fifo_mem[rd_ptr];
      end
      if (push && !pop)      count <= count + 3'd1;
      else if (pop && !push) count <= count - 3'd1;
    end
  end
`else
  logic [7:0] rx_hold;
  logic       rx_full;

  assign rx_valid    = rx_full;
  assign pop         = rd_data && rx_full;
  assign push        = rx_byte_stb && (!rx_full || pop);
  assign overrun_set = rx_byte_stb && rx_full && !pop;
  assign rx_byte_rd  = rx_hold;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_hold <= '0;
      rx_full <= 1'b0;
    end else if (push) begin
      rx_hold <= rx_byte;
      rx_full <= 1'b1;
    end else if (pop) begin
      rx_full <= 1'b0;
    end
  end
`endif

  // ---------------- registers / interrupt ----------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      baud         <= DEFAULT_DIV;
      ctrl         <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      tx_drop      <= 1'b0;
      o_int        <= 1'b0;
    end else begin
      if (wr && off == REG_BAUD) baud <= i_wb_dat;
      if (wr && off == REG_CTRL) ctrl <= i_wb_dat[1:0];
      if (wr && off == REG_STATUS) begin
        if (i_wb_dat[ST_RX_OVERRUN])   rx_overrun   <= 1'b0;
        if (i_wb_dat[ST_RX_FRAME_ERR]) rx_frame_err <= 1'b0;
        if (i_wb_dat[ST_TX_DROP])      tx_drop      <= 1'b0;
      end
      // Set events come last so they win over a same-cycle clear.
      if (overrun_set)         rx_overrun   <= 1'b1;
      if (rx_frame_stb)        rx_frame_err <= 1'b1;
      if (wr_data && tx_busy)  tx_drop      <= 1'b1;
      o_int <= (ctrl[CTRL_RX_INT_EN] & rx_valid) | (ctrl[CTRL_TX_INT_EN] & ~tx_busy);
    end
  end

  always_comb begin
    o_wb_dat = '0;
    if (o_sel) begin
      case (off)
        REG_DATA: o_wb_dat = {8'h00, rx_byte_rd};
        REG_STATUS: begin
          o_wb_dat[ST_RX_VALID]     = rx_valid;
          o_wb_dat[ST_TX_BUSY]      = tx_busy;
          o_wb_dat[ST_RX_OVERRUN]   = rx_overrun;
          o_wb_dat[ST_RX_FRAME_ERR] = rx_frame_err;
          o_wb_dat[ST_TX_DROP]      = tx_drop;
        end
        REG_BAUD: o_wb_dat = baud;
        REG_CTRL: o_wb_dat = {14'h0, ctrl};
        default:  o_wb_dat = '0;
      endcase
    end
  end

endmodule
